// File: rtl/ring_sequence_checker.sv
`default_nettype none
// ============================================================================
// Module      : ring_sequence_checker
// Description : Receive-side monitor for a 4-bit ring/sequence counter bus
//               that counts 1, 2, ..., SEQ_LEN, 1, ...  Locks onto the legal
//               sequence, decodes the current position to one-hot, flags
//               out-of-sequence samples and counts errors and wraps.
// Ports       : clk        - clock, rising edge
//               rst        - asynchronous active-high reset
//               en         - q_in is sampled on this cycle
//               q_in       - counter value under check
//               clr        - synchronous clear of err_count / wrap_count
//               locked     - checker is in LOCKED state
//               err        - one-cycle pulse on a violation while LOCKED
//               wrap       - one-cycle pulse on SEQ_LEN->1 while LOCKED
//               err_count  - saturating violation count
//               wrap_count - wrap count, modulo 2^WRAP_CNT_W
//               onehot     - bit (v-1) set for last legal sample v
// Revision    : 1.0 - initial release
// ============================================================================
module ring_sequence_checker #(
  parameter int SEQ_LEN    = 4,
  parameter int LOCK_CNT   = 2,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [3:0]            q_in,
  input  logic                  clr,
  output logic                  locked,
  output logic                  err,
  output logic                  wrap,
  output logic [ERR_CNT_W-1:0]  err_count,
  output logic [WRAP_CNT_W-1:0] wrap_count,
  output logic [SEQ_LEN-1:0]    onehot
);

  localparam logic [0:0] HUNT   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  localparam logic [3:0] C_SEQ_LAST = 4'(SEQ_LEN);
  localparam logic [3:0] C_LOCK     = 4'(LOCK_CNT);

  logic [0:0]            state_q, state_d;
  logic [3:0]            prev_q, prev_d;
  logic                  prev_valid_q, prev_valid_d;
  logic [3:0]            match_q, match_d;
  logic                  err_q, err_d;
  logic                  wrap_q, wrap_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
  logic [WRAP_CNT_W-1:0] wrap_count_q, wrap_count_d;
  logic [SEQ_LEN-1:0]    onehot_q, onehot_d;

  logic                  w_legal;
  logic [3:0]            w_succ;
  logic                  w_is_succ;
  logic [SEQ_LEN-1:0]    w_onehot_s;

  assign w_legal   = (q_in != 4'd0) && (q_in <= C_SEQ_LAST);
  assign w_succ    = (prev_q == C_SEQ_LAST) ? 4'd1 : prev_q + 4'd1;
  assign w_is_succ = (q_in == w_succ);

  // Direct compare decode avoids a variable shift of a SEQ_LEN-wide vector.
  genvar i;
  generate
    for (i = 0; i < SEQ_LEN; i++) begin : g_onehot
      assign w_onehot_s[i] = (q_in == 4'(i + 1));
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    match_d      = match_q;
    onehot_d     = onehot_q;
    err_d        = 1'b0;
    wrap_d       = 1'b0;

    if (en) begin
      case (state_q)
        HUNT: begin
          if (!w_legal) begin
            match_d      = 4'd0;
            prev_valid_d = 1'b0;
            onehot_d     = '0;
          end else begin
            prev_d       = q_in;
            prev_valid_d = 1'b1;
            onehot_d     = w_onehot_s;
            if (prev_valid_q && w_is_succ) begin
              if (match_q + 4'd1 == C_LOCK) begin
                state_d = LOCKED;
                match_d = 4'd0;
              end else begin
                match_d = match_q + 4'd1;
              end
            end else begin
              match_d = 4'd0;
            end
          end
        end
        LOCKED: begin
          // prev is always legal here, so a successor match implies legal q_in.
          if (w_is_succ) begin
            prev_d   = q_in;
            onehot_d = w_onehot_s;
            wrap_d   = (prev_q == C_SEQ_LAST);
          end else begin
            err_d   = 1'b1;
            state_d = HUNT;
            match_d = 4'd0;
            if (w_legal) begin
              prev_d       = q_in;
              prev_valid_d = 1'b1;
              onehot_d     = w_onehot_s;
            end else begin
              prev_valid_d = 1'b0;
              onehot_d     = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // clr wins over a same-edge increment; the pulses themselves are unaffected.
  always_comb begin
    err_count_d = err_count_q;
    if (clr) begin
      err_count_d = '0;
    end else if (err_d && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  always_comb begin
    wrap_count_d = wrap_count_q;
    if (clr) begin
      wrap_count_d = '0;
    end else if (wrap_d) begin
      wrap_count_d = wrap_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      prev_q       <= 4'd0;
      prev_valid_q <= 1'b0;
      match_q      <= 4'd0;
      err_q        <= 1'b0;
      wrap_q       <= 1'b0;
      err_count_q  <= '0;
      wrap_count_q <= '0;
      onehot_q     <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      match_q      <= match_d;
      err_q        <= err_d;
      wrap_q       <= wrap_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
      onehot_q     <= onehot_d;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign err        = err_q;
  assign wrap       = wrap_q;
  assign err_count  = err_count_q;
  assign wrap_count = wrap_count_q;
  assign onehot     = onehot_q;

endmodule
`default_nettype wire
